// File: rtl/i2s_rx_deser_if.sv
// Bundle for the I2S receive path: serial inputs (word select, data) plus
// the deserialized word and its per-channel strobes.
interface i2s_rx_deser_if #(
  parameter int unsigned DATA_WIDTH = 8
) ();
  logic                  lrck;
  logic                  sdin;
  logic [DATA_WIDTH-1:0] data;
  logic                  l_vld;
  logic                  r_vld;
  logic                  synced;

  // Serial source side: drives the wire pair, observes the recovered words.
  modport master (
    output lrck,
    output sdin,
    input  data,
    input  l_vld,
    input  r_vld,
    input  synced
  );

  // Deserializer side.
  modport slave (
    input  lrck,
    input  sdin,
    output data,
    output l_vld,
    output r_vld,
    output synced
  );
endinterface

// File: rtl/i2s_rx_deser.sv
// I2S receive deserializer: rebuilds left/right words MSB-first from sdin,
// presenting each completed word on data with a one-cycle channel strobe.
module i2s_rx_deser #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input logic            sck,
  input logic            rst_n,
  i2s_rx_deser_if.slave  bus
);

  localparam int unsigned CW = $clog2(DATA_WIDTH + 1);

  if (DATA_WIDTH < 2) begin : g_width_check
    $error("i2s_rx_deser: DATA_WIDTH must be at least 2");
  end

  typedef enum logic [1:0] {
    ST_UNPRIMED = 2'd0,
    ST_HUNT     = 2'd1,
    ST_LOCKED   = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  ws_d_q, ws_d_d;
  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  l_vld_q, l_vld_d;
  logic                  r_vld_q, r_vld_d;
  logic                  synced_q, synced_d;

  logic                  ws_edge;
  logic                  have_room;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] word;

  always_comb begin
    state_d   = state_q;
    ws_d_d    = bus.lrck;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    data_d    = data_q;
    l_vld_d   = 1'b0;
    r_vld_d   = 1'b0;
    synced_d  = synced_q;

    ws_edge   = (state_q != ST_UNPRIMED) && (bus.lrck != ws_d_q);
    have_room = bit_cnt_q < CW'(DATA_WIDTH);
    shifted   = {shreg_q[DATA_WIDTH-2:0], bus.sdin};
    // shifted holds bit_cnt+1 valid bits at the bottom; move them to the top.
    word      = have_room ? (shifted << (CW'(DATA_WIDTH - 1) - bit_cnt_q))
                          : shreg_q;

    if (state_q == ST_UNPRIMED) begin
      state_d = ST_HUNT;
    end

    if (ws_edge) begin
      bit_cnt_d = '0;
      shreg_d   = '0;
      if (state_q == ST_LOCKED) begin
        data_d  = word;
        l_vld_d = ~ws_d_q;
        r_vld_d = ws_d_q;
      end else begin
        // First boundary after reset only aligns; the partial word is dropped.
        state_d  = ST_LOCKED;
        synced_d = 1'b1;
      end
    end else if (have_room) begin
      shreg_d   = shifted;
      bit_cnt_d = bit_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge sck or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_UNPRIMED;
      ws_d_q    <= 1'b0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      data_q    <= '0;
      l_vld_q   <= 1'b0;
      r_vld_q   <= 1'b0;
      synced_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ws_d_q    <= ws_d_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      l_vld_q   <= l_vld_d;
      r_vld_q   <= r_vld_d;
      synced_q  <= synced_d;
    end
  end

  assign bus.data   = data_q;
  assign bus.l_vld  = l_vld_q;
  assign bus.r_vld  = r_vld_q;
  assign bus.synced = synced_q;

endmodule

// File: doc/i2s_rx_deser.md
Name: i2s_rx_deser

Overview:
- I2S receive deserializer for the audio path.
- Samples serial data `sdin` and word-select `lrck` on rising `sck` and rebuilds left/right words MSB-first.
- Presents each word on `data` with a one-cycle `l_vld` or `r_vld` strobe.
- Feeds the downstream per-channel holding stage (`ldata`/`rdata` capture on `l_vld`/`r_vld`) directly, on the same clock.

Parameters:
- DATA_WIDTH, 8, captured word width in bits. Must be ≥ 2.

Ports:
- sck      input   1           I2S bit clock; all logic on rising edge.
- rst_n    input   1           asynchronous, active-low reset.
- lrck     input   1           word select; 0 = left channel, 1 = right channel; changes on falling `sck`.
- sdin     input   1           serial data; MSB arrives one `sck` after an `lrck` transition (standard I2S).
- data     output  DATA_WIDTH  last completed word, left-justified; holds between strobes.
- l_vld    output  1           one-cycle strobe: `data` is a left word.
- r_vld    output  1           one-cycle strobe: `data` is a right word.
- synced   output  1           high once the first `lrck` transition after reset has been seen.

Behaviour:
- Reset values: `data`=0, `l_vld`=0, `r_vld`=0, `synced`=0. Internal state also clears: `ws_d`=0, `primed`=0, `bit_cnt`=0, `shreg`=0.
- Priming: the first `sck` edge after reset release loads `ws_d`<=`lrck` and sets `primed`. No edge detection occurs on that edge.
- Edge detect: `ws_edge` = `primed` & (`lrck` != `ws_d`). `ws_d`<=`lrck` every edge.
- Bit counter `bit_cnt` (0..DATA_WIDTH, saturating) counts bits shifted into the current word.
- Non-edge cycle:
  - If `bit_cnt` < DATA_WIDTH: `shreg`<={`shreg`[W-2:0],`sdin`} and `bit_cnt`++.
  - Otherwise `sdin` is ignored. Slots longer than DATA_WIDTH are truncated, keeping the MSBs.
- `ws_edge` cycle: the `sdin` bit on this edge is the LSB slot of the word just ending.
  - Let n = `bit_cnt` + 1 if `bit_cnt` < DATA_WIDTH, else n = DATA_WIDTH.
  - Word = the n collected bits, including the current `sdin` when `bit_cnt` < DATA_WIDTH, left-justified with zero pad in the low DATA_WIDTH−n bits.
  - If `synced`=1: `data`<=word; `l_vld`<=(`ws_d`==0); `r_vld`<=(`ws_d`==1).
  - If `synced`=0: no strobe, `data` unchanged, and `synced`<=1. This discards the partial first word.
  - Always: `bit_cnt`<=0 and `shreg`<=0.
- Latency: `data`/strobe are valid in the `sck` cycle immediately following the edge on which the `lrck` change is first sampled. Strobe is high exactly one cycle.
- `l_vld` and `r_vld` are never high together. Between strobes both are 0 and `data` holds.
- `lrck` constant: no strobes ever; `bit_cnt` saturates at DATA_WIDTH.
- Zero-length slot (`lrck` toggles on consecutive edges): n=1, word = {`sdin`, zeros}. A strobe is still issued.
- Reset mid-word: everything clears immediately (async). After release, priming and sync repeat, so the first post-reset word boundary is discarded.
- Downstream capture: the holding stage registers `data` on the next `sck` edge while the strobe is high, giving two-cycle total latency from the `lrck` change sample.

Test Plan:
- W=8, 8-bit slots, left=0xA5, right=0x3C, three frames → first boundary sets `synced`, no strobe. Then alternating `l_vld` with `data`=0xA5 and `r_vld` with `data`=0x3C, each 1 cycle wide, one cycle after the sampled `lrck` change. Downstream stage shows `ldata`=0xA5, `rdata`=0x3C.
- W=8, 16-bit slots, left=0xBEEF, right=0x1234 → `data`=0xBE on `l_vld`, 0x12 on `r_vld`; trailing bits ignored.
- W=8, 6-bit slots, left bits 101101 → `data`=0xB4 on `l_vld` (zero-padded low bits).
- `lrck` held high with `sdin` toggling for 100 `sck` → `l_vld`=`r_vld`=0 throughout, `synced`=0, `data`=0.
- Assert `rst_n` low mid-right-word after sync → all outputs 0 immediately. After release, the first boundary gives no strobe; the next full left word (0xA5) strobes correctly.
- Release reset with `lrck`=1 on the first edge → no spurious `ws_edge`; `synced` rises only on the first true `lrck` fall.
